sdp_ram_read_arbiter: RTL
=========================

Name: sdp_ram_read_arbiter

Overview:
- Round-robin arbiter that shares the single read port (port B) of a simple-dual-port block RAM between NUM_REQ read requesters.
- Issues at most one read per cycle and tracks in-flight reads through the RAM's fixed read latency.
- Returns each read's data tagged with the requester ID.
- Snoops the RAM write port so a same-address read/write collision can be resolved; see Optional Feature.

Parameters:
- ADDR_WIDTH, 10, RAM address width.
- DATA_WIDTH, 64, RAM data width.
- NUM_REQ, 4, number of read requesters; legal range 1..16.
- PIPELINE_DEPTH, 1, RAM output pipeline depth. Read latency LAT = PIPELINE_DEPTH+1 cycles.
- ID_W, derived: max(1, $clog2(NUM_REQ)).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester read request
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i uses slice [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_ready  out  NUM_REQ  one-hot grant; request i is accepted when req_valid[i] & req_ready[i]
- wr_en  in  1  snoop of RAM port A enable AND-reduced with any write byte-enable
- wr_addr  in  ADDR_WIDTH  snoop of RAM port A address
- ram_b_en  out  1  to RAM port B enable
- ram_b_addr  out  ADDR_WIDTH  to RAM port B address
- ram_b_rdata  in  DATA_WIDTH  from RAM port B read data
- rsp_valid  out  1  read data valid this cycle
- rsp_id  out  ID_W  requester that owns rsp_data
- rsp_data  out  DATA_WIDTH  read data
- busy  out  1  high while any read is in flight

Behaviour:
- Reset (asynchronous, rst_n=0):
  - Round-robin pointer rr_ptr=0.
  - In-flight shift register cleared (all valid bits 0, IDs 0).
  - rsp_valid=0, busy=0.
  - req_ready and ram_b_en are 0 while rst_n=0.
  - Reads already in the RAM pipeline when reset asserts are discarded; no response is produced for them after reset releases.
- Arbitration (combinational, same cycle):
  - Grant goes to the first requester index k, searching rr_ptr, rr_ptr+1, ... wrapping modulo NUM_REQ, with req_valid[k]=1.
  - req_ready[k]=1 and all other bits are 0. req_ready is all 0 when no requester is valid.
  - req_ready may depend combinationally on req_valid. Requesters must not make req_valid depend on req_ready.
- Issue:
  - ram_b_en = |(req_valid & req_ready).
  - ram_b_addr = req_addr slice of k; it is 0 when there is no grant.
  - No backpressure; one read issues per cycle maximum.
- Pointer update: on a grant, rr_ptr <= (k+1) mod NUM_REQ; otherwise it holds. With NUM_REQ=1, rr_ptr stays 0.
- Tracking:
  - LAT-entry shift register of {valid, id}. Stage 0 loads {ram_b_en, k} every cycle.
  - The tail entry drives rsp_valid and rsp_id. rsp_data = ram_b_rdata (combinational passthrough).
  - A request accepted in cycle t returns in cycle t+LAT.
- Ordering: responses leave in issue order. Back-to-back grants yield back-to-back responses. The response path cannot stall; consumers must always accept.
- busy = OR of all valid bits in the shift register.
- Fairness: a continuously asserted requester is granted at least once every NUM_REQ grants.
- Requester-side rule: once req_valid is asserted, req_addr stays stable until accepted. The arbiter does not check this.

Optional Feature:
- Macro: SDP_RAM_ARB_RAW_STALL_EN.
- Defined:
  - If wr_en=1 and wr_addr equals the granted address, the grant is suppressed that cycle: req_ready=0, ram_b_en=0, rr_ptr holds.
  - The same requester wins next cycle if the collision has cleared, so the read never returns old or undefined data for a same-cycle write.
- Undefined:
  - No comparison is made; the grant proceeds.
  - Read data for a same-cycle same-address collision is undefined. The bench must not check data in that case.

Test Plan:
- Reset/idle: NUM_REQ=4, LAT=2; hold rst_n=0 for 3 cycles, then release with no requests -> req_ready=0000, ram_b_en=0, rsp_valid=0, busy=0 on every cycle.
- Single read: preload mem[0x05]=0xAA; req_valid=0010 with addr 0x05 at t -> req_ready=0010 at t; ram_b_addr=0x05 at t; rsp_valid=1, rsp_id=1, rsp_data=0xAA at t+2 only.
- Round-robin: req_valid=1111 held for 8 cycles -> grant order 0,1,2,3,0,1,2,3; responses at t+2..t+9 carry IDs in the same order with correct data.
- Pointer wrap/skip: rr_ptr=3 and req_valid=0101 -> grant 0, then 2, then 0; rr_ptr sequence 1, 3, 1.
- Reset mid-flight: grant reads at t and t+1, assert rst_n=0 at t+1 -> no rsp_valid after release; busy=0; next grant goes to requester 0.
- Collision with SDP_RAM_ARB_RAW_STALL_EN defined: wr_en=1, wr_addr=0x10 writing 0x55 while requester 2 reads 0x10 -> req_ready=0 that cycle, grant next cycle, response data 0x55. With the macro undefined, the grant occurs in the collision cycle.

Source files
------------

// File: rtl/sdp_ram_read_arbiter.sv
// Round-robin arbiter sharing port B of a simple-dual-port RAM between NUM_REQ readers.
// Optional macro SDP_RAM_ARB_RAW_STALL_EN stalls a grant that collides with a same-address write.
module sdp_ram_read_arbiter #(
  parameter int ADDR_WIDTH     = 10,
  parameter int DATA_WIDTH     = 64,
  parameter int NUM_REQ        = 4,
  parameter int PIPELINE_DEPTH = 1,
  localparam int ID_W          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int LAT           = PIPELINE_DEPTH + 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          wr_en,
  input  logic [ADDR_WIDTH-1:0]         wr_addr,
  output logic                          ram_b_en,
  output logic [ADDR_WIDTH-1:0]         ram_b_addr,
  input  logic [DATA_WIDTH-1:0]         ram_b_rdata,
  output logic                          rsp_valid,
  output logic [ID_W-1:0]               rsp_id,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic                          busy
);

  logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic                  grant_found;
  logic [ID_W-1:0]       grant_idx;
  logic [ADDR_WIDTH-1:0] grant_addr;
  logic                  collision;
  logic                  issue;

  logic [LAT-1:0]        vld_q;
  logic [ID_W-1:0]       id_q [LAT];

  // Scan offsets from farthest to nearest so the requester closest to rr_ptr wins last.
  always_comb begin : grant_search
    int idx;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      idx = int'(rr_ptr_q) + off;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req_valid[idx]) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(idx);
      end
    end
  end

  assign grant_addr = req_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];

`ifdef SDP_RAM_ARB_RAW_STALL_EN
  assign collision = grant_found && wr_en && (wr_addr == grant_addr);
`else
  logic unused_snoop;
  assign unused_snoop = ^{wr_en, wr_addr};
  assign collision    = 1'b0;
`endif

  // rst_n gates the grant directly so nothing is accepted while reset is held.
  assign issue      = grant_found && !collision && rst_n;
  assign req_ready  = issue ? (NUM_REQ'(1) << grant_idx) : '0;
  assign ram_b_en   = issue;
  assign ram_b_addr = issue ? grant_addr : '0;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (issue) begin
      rr_ptr_d = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: the tracking pipeline is reset so reads in flight at reset never produce a response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
      vld_q    <= '0;
      for (int i = 0; i < LAT; i++) id_q[i] <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      vld_q[0] <= issue;
      id_q[0]  <= issue ? grant_idx : '0;
      for (int i = 1; i < LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        id_q[i]  <= id_q[i-1];
      end
    end
  end

  assign rsp_valid = vld_q[LAT-1];
  assign rsp_id    = id_q[LAT-1];
  assign rsp_data  = ram_b_rdata;
  assign busy      = |vld_q;

endmodule
